decode_stage_q: RTL and testbench

- Buffered, handshaked RV32I decode stage between fetch and execute; successor to the combinational decoder.
- Accepts {pc, inst} from fetch into a DEPTH-entry queue and decodes the queue head.
- Registers the decoded bundle into an output pipeline register with valid/ready backpressure.
- Adds illegal-instruction detection and flush; pc width is parametrised.

---
 rtl/decode_stage_q.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_decode_stage_q.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_q.sv
// -----------------------------------------------------------------------------
// decode_stage_q
//   Buffered, handshaked RV32I decode stage sitting between fetch and execute.
//   Fetch pushes {pc, inst} into a DEPTH-entry FIFO. The FIFO head is decoded
//   combinationally, and the decoded bundle is captured in an output register
//   that uses valid/ready backpressure. Flush discards everything in flight.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   XLEN  : pc width in bits
//
// Optional feature
//   DECODE_RV32M_EN : when defined, OP with funct7 = 0000001 (RV32M) is legal
//                     and the ports out_is_muldiv / out_muldiv_op exist.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : drop the FIFO contents and the output bundle
//   in_valid/in_ready     : fetch handshake (in_ready = FIFO not full)
//   in_inst, in_pc        : instruction word and its address
//   out_valid/out_ready   : execute handshake
//   out_pc, out_rs1/2/rd  : pc and raw register fields
//   out_imm               : sign-extended immediate (0 for R-type)
//   out_alu_op, out_ls_op : ALU operation / load-store width (funct3)
//   out_is_sub/sra        : R-type funct7[5] qualifiers (sra also for SRAI)
//   out_is_*              : instruction class flags
//   out_in1_pc/in2_imm    : ALU operand selects
//   out_wb                : instruction writes rd
//   out_illegal           : instruction is not a legal encoding
// -----------------------------------------------------------------------------
module decode_stage_q #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_imm,
    output logic [2:0]      out_alu_op,
    output logic [2:0]      out_ls_op,
    output logic            out_is_sub,
    output logic            out_is_sra,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_is_system,
    output logic            out_in1_pc,
    output logic            out_in2_imm,
    output logic            out_wb,
`ifdef DECODE_RV32M_EN
    output logic            out_is_muldiv,
    output logic [2:0]      out_muldiv_op,
`endif
    output logic            out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic [2:0]  ls_op;
        logic        is_sub;
        logic        is_sra;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_system;
        logic        in1_pc;
        logic        in2_imm;
        logic        wb;
`ifdef DECODE_RV32M_EN
        logic        is_muldiv;
        logic [2:0]  muldiv_op;
`endif
        logic        illegal;
    } dec_t;

    // ---------------- stage p0: instruction FIFO + combinational decode ----
    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, push, load;

    logic [31:0]     inst_p0;
    logic [XLEN-1:0] pc_p0;
    dec_t            dec_p0;
    logic            legal_p0;
    logic [6:0]      opc_p0, f7_p0;
    logic [2:0]      f3_p0;

    dec_t            bundle_p1;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full;
    // full blocks a push even if the head leaves this cycle
    assign push     = in_valid && !full && !flush;
    assign load     = !empty && (!vld_p1 || out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= in_inst;
            q_pc[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign inst_p0 = q_inst[rd_ptr];
    assign pc_p0   = q_pc[rd_ptr];
    assign opc_p0  = inst_p0[6:0];
    assign f3_p0   = inst_p0[14:12];
    assign f7_p0   = inst_p0[31:25];

    always_comb begin
        dec_p0        = '0;
        legal_p0      = 1'b0;
        dec_p0.rs1    = inst_p0[19:15];
        dec_p0.rs2    = inst_p0[24:20];
        dec_p0.rd     = inst_p0[11:7];
        dec_p0.alu_op = f3_p0;
        dec_p0.ls_op  = f3_p0;
`ifdef DECODE_RV32M_EN
        dec_p0.muldiv_op = f3_p0;
`endif
        case (opc_p0)
            OPC_LUI: begin
                dec_p0.imm     = {inst_p0[31:12], 12'b0};
                dec_p0.in2_imm = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.alu_op  = 3'b000;
                legal_p0       = 1'b1;
            end
            OPC_AUIPC: begin
                dec_p0.imm     = {inst_p0[31:12], 12'b0};
                dec_p0.in1_pc  = 1'b1;
                dec_p0.in2_imm = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.alu_op  = 3'b000;
                legal_p0       = 1'b1;
            end
            OPC_JAL: begin
                dec_p0.imm     = {{11{inst_p0[31]}}, inst_p0[31], inst_p0[19:12],
                                  inst_p0[20], inst_p0[30:21], 1'b0};
                dec_p0.in1_pc  = 1'b1;
                dec_p0.in2_imm = 1'b1;
                dec_p0.is_jal  = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.alu_op  = 3'b000;
                legal_p0       = 1'b1;
            end
            OPC_JALR: begin
                dec_p0.imm     = {{20{inst_p0[31]}}, inst_p0[31:20]};
                dec_p0.in2_imm = 1'b1;
                dec_p0.is_jalr = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.alu_op  = 3'b000;
                legal_p0       = (f3_p0 == 3'b000);
            end
            OPC_BRANCH: begin
                dec_p0.imm       = {{19{inst_p0[31]}}, inst_p0[31], inst_p0[7],
                                    inst_p0[30:25], inst_p0[11:8], 1'b0};
                dec_p0.in1_pc    = 1'b1;
                dec_p0.in2_imm   = 1'b1;
                dec_p0.is_branch = 1'b1;
                dec_p0.alu_op    = 3'b000;
                // 010 and 011 are the two unused branch conditions
                legal_p0         = (f3_p0[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec_p0.imm     = {{20{inst_p0[31]}}, inst_p0[31:20]};
                dec_p0.in2_imm = 1'b1;
                dec_p0.is_load = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.alu_op  = 3'b000;
                legal_p0       = (f3_p0 != 3'b011) && (f3_p0[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec_p0.imm      = {{20{inst_p0[31]}}, inst_p0[31:25], inst_p0[11:7]};
                dec_p0.in2_imm  = 1'b1;
                dec_p0.is_store = 1'b1;
                dec_p0.alu_op   = 3'b000;
                legal_p0        = (f3_p0 <= 3'b010);
            end
            OPC_OP_IMM: begin
                dec_p0.imm     = {{20{inst_p0[31]}}, inst_p0[31:20]};
                dec_p0.in2_imm = 1'b1;
                dec_p0.wb      = 1'b1;
                dec_p0.is_sra  = (f3_p0 == 3'b101) && inst_p0[30];
                // shift-immediates reuse imm[11:5] as funct7
                if (f3_p0 == 3'b001)
                    legal_p0 = (f7_p0 == 7'b0000000);
                else if (f3_p0 == 3'b101)
                    legal_p0 = (f7_p0 == 7'b0000000) || (f7_p0 == 7'b0100000);
                else
                    legal_p0 = 1'b1;
            end
            OPC_OP: begin
                dec_p0.wb     = 1'b1;
                dec_p0.is_sub = (f3_p0 == 3'b000) && inst_p0[30];
                dec_p0.is_sra = (f3_p0 == 3'b101) && inst_p0[30];
                legal_p0      = (f7_p0 == 7'b0000000) ||
                                ((f7_p0 == 7'b0100000) &&
                                 ((f3_p0 == 3'b000) || (f3_p0 == 3'b101)));
`ifdef DECODE_RV32M_EN
                if (f7_p0 == 7'b0000001) begin
                    dec_p0.is_muldiv = 1'b1;
                    legal_p0         = 1'b1;
                end
`endif
            end
            OPC_MISC_MEM: begin
                dec_p0.imm = {{20{inst_p0[31]}}, inst_p0[31:20]};
                legal_p0   = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_p0.imm       = {{20{inst_p0[31]}}, inst_p0[31:20]};
                dec_p0.is_system = 1'b1;
                legal_p0         = 1'b1;
            end
            default: legal_p0 = 1'b0;
        endcase

        if (inst_p0[1:0] != 2'b11) legal_p0 = 1'b0;

        // an illegal instruction must not cause side effects downstream;
        // pc and register fields are kept for the trap handler
        if (!legal_p0) begin
            dec_p0.wb        = 1'b0;
            dec_p0.is_load   = 1'b0;
            dec_p0.is_store  = 1'b0;
            dec_p0.is_branch = 1'b0;
            dec_p0.is_jal    = 1'b0;
            dec_p0.is_jalr   = 1'b0;
        end
        dec_p0.illegal = !legal_p0;
    end

    // ---------------- stage p1: output pipeline register -------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            bundle_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1    <= 1'b1;
            pc_p1     <= pc_p0;
            bundle_p1 <= dec_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid     = vld_p1;
    assign out_pc        = pc_p1;
    assign out_rs1       = bundle_p1.rs1;
    assign out_rs2       = bundle_p1.rs2;
    assign out_rd        = bundle_p1.rd;
    assign out_imm       = bundle_p1.imm;
    assign out_alu_op    = bundle_p1.alu_op;
    assign out_ls_op     = bundle_p1.ls_op;
    assign out_is_sub    = bundle_p1.is_sub;
    assign out_is_sra    = bundle_p1.is_sra;
    assign out_is_load   = bundle_p1.is_load;
    assign out_is_store  = bundle_p1.is_store;
    assign out_is_branch = bundle_p1.is_branch;
    assign out_is_jal    = bundle_p1.is_jal;
    assign out_is_jalr   = bundle_p1.is_jalr;
    assign out_is_system = bundle_p1.is_system;
    assign out_in1_pc    = bundle_p1.in1_pc;
    assign out_in2_imm   = bundle_p1.in2_imm;
    assign out_wb        = bundle_p1.wb;
`ifdef DECODE_RV32M_EN
    assign out_is_muldiv = bundle_p1.is_muldiv;
    assign out_muldiv_op = bundle_p1.muldiv_op;
`endif
    assign out_illegal   = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage_q.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_q
//   Directed bench for decode_stage_q with a queue-based reference model of
//   the buffered decoder and literal expectations for the key instructions.
// -----------------------------------------------------------------------------
module tb_decode_stage_q;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [31:0]     out_imm;
    logic [2:0]      out_alu_op, out_ls_op;
    logic            out_is_sub, out_is_sra, out_is_load, out_is_store;
    logic            out_is_branch, out_is_jal, out_is_jalr, out_is_system;
    logic            out_in1_pc, out_in2_imm, out_wb, out_illegal;
`ifdef DECODE_RV32M_EN
    logic            out_is_muldiv;
    logic [2:0]      out_muldiv_op;
`endif

    decode_stage_q #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_ls_op(out_ls_op),
        .out_is_sub(out_is_sub), .out_is_sra(out_is_sra),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
        .out_is_jalr(out_is_jalr), .out_is_system(out_is_system),
        .out_in1_pc(out_in1_pc), .out_in2_imm(out_in2_imm), .out_wb(out_wb),
`ifdef DECODE_RV32M_EN
        .out_is_muldiv(out_is_muldiv), .out_muldiv_op(out_muldiv_op),
`endif
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  alu_op, ls_op;
        logic is_sub, is_sra, is_load, is_store, is_branch, is_jal, is_jalr, is_system;
        logic in1_pc, in2_imm, wb;
`ifdef DECODE_RV32M_EN
        logic is_muldiv;
        logic [2:0] muldiv_op;
`endif
        logic illegal;
    } exp_t;

    typedef enum {F_NONE, F_I, F_S, F_B, F_U, F_J} fmt_t;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    bit   m_ov = 1'b0;

    // ---------------- reference model -------------------------------------
    function automatic logic [31:0] imm_of(input fmt_t f, input logic [31:0] inst);
        int v;
        v = 0;
        case (f)
            F_I: v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            F_S: v = int'({inst[31:25], inst[11:7]}) - (inst[31] ? 4096 : 0);
            F_B: v = 2 * int'(inst[11:8]) + 32 * int'(inst[30:25])
                     + 2048 * int'(inst[7]) - (inst[31] ? 4096 : 0);
            F_U: v = int'(inst[31:12]) * 4096;
            F_J: v = 2 * int'(inst[30:21]) + 2048 * int'(inst[20])
                     + 4096 * int'(inst[19:12]) - (inst[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit m_legal(input logic [31:0] inst);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
        if (inst[1:0] != 2'b11) return 1'b0;
        case (op)
            7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73: return 1'b1;
            7'h67: return f3 == 3'd0;
            7'h63: return !(f3 == 3'd2 || f3 == 3'd3);
            7'h03: return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            7'h23: return f3 <= 3'd2;
            7'h13: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
                return 1'b1;
            end
            7'h33: begin
                if (f7 == 7'h00) return 1'b1;
                if (f7 == 7'h20) return f3 == 3'd0 || f3 == 3'd5;
`ifdef DECODE_RV32M_EN
                if (f7 == 7'h01) return 1'b1;
`endif
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t m_decode(input logic [XLEN-1:0] pc, input logic [31:0] inst);
        exp_t e;
        fmt_t f;
        bit   add_op;
        logic [2:0] f3;
        e = '0; f = F_NONE; add_op = 1'b0; f3 = inst[14:12];
        e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        e.ls_op = f3;
`ifdef DECODE_RV32M_EN
        e.muldiv_op = f3;
`endif
        case (inst[6:0])
            7'h37: begin f = F_U; add_op = 1; e.in2_imm = 1; e.wb = 1; end
            7'h17: begin f = F_U; add_op = 1; e.in1_pc = 1; e.in2_imm = 1; e.wb = 1; end
            7'h6F: begin f = F_J; add_op = 1; e.in1_pc = 1; e.in2_imm = 1; e.is_jal = 1; e.wb = 1; end
            7'h67: begin f = F_I; add_op = 1; e.in2_imm = 1; e.is_jalr = 1; e.wb = 1; end
            7'h63: begin f = F_B; add_op = 1; e.in1_pc = 1; e.in2_imm = 1; e.is_branch = 1; end
            7'h03: begin f = F_I; add_op = 1; e.in2_imm = 1; e.is_load = 1; e.wb = 1; end
            7'h23: begin f = F_S; add_op = 1; e.in2_imm = 1; e.is_store = 1; end
            7'h13: begin f = F_I; e.in2_imm = 1; e.wb = 1; e.is_sra = (f3 == 3'd5) && inst[30]; end
            7'h33: begin
                e.wb = 1;
                e.is_sub = (f3 == 3'd0) && inst[30];
                e.is_sra = (f3 == 3'd5) && inst[30];
`ifdef DECODE_RV32M_EN
                e.is_muldiv = (inst[31:25] == 7'h01);
`endif
            end
            7'h0F: f = F_I;
            7'h73: begin f = F_I; e.is_system = 1; end
            default: f = F_NONE;
        endcase
        e.alu_op = add_op ? 3'd0 : f3;
        e.imm    = imm_of(f, inst);
        if (!m_legal(inst)) begin
            e.illegal = 1; e.wb = 0; e.is_load = 0; e.is_store = 0;
            e.is_branch = 0; e.is_jal = 0; e.is_jalr = 0;
        end
        return e;
    endfunction

    function automatic exp_t get_act();
        exp_t a;
        a = '0;
        a.pc = out_pc; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
        a.imm = out_imm; a.alu_op = out_alu_op; a.ls_op = out_ls_op;
        a.is_sub = out_is_sub; a.is_sra = out_is_sra; a.is_load = out_is_load;
        a.is_store = out_is_store; a.is_branch = out_is_branch; a.is_jal = out_is_jal;
        a.is_jalr = out_is_jalr; a.is_system = out_is_system; a.in1_pc = out_in1_pc;
        a.in2_imm = out_in2_imm; a.wb = out_wb; a.illegal = out_illegal;
`ifdef DECODE_RV32M_EN
        a.is_muldiv = out_is_muldiv; a.muldiv_op = out_muldiv_op;
`endif
        return a;
    endfunction

    // ---------------- per-cycle comparison against the model --------------
    initial begin
        int   qcnt;
        bit   ld, ps;
        exp_t act;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_ov = 1'b0;
            end else begin
                qcnt = exp_q.size() - (m_ov ? 1 : 0);
                checks++;
                if (out_valid !== m_ov) begin
                    errors++;
                    $display("FAIL model_out_valid t=%0t got %b expected %b", $time, out_valid, m_ov);
                end
                checks++;
                if (in_ready !== (qcnt != DEPTH)) begin
                    errors++;
                    $display("FAIL model_in_ready t=%0t got %b expected %b", $time, in_ready, qcnt != DEPTH);
                end
                if (m_ov && out_valid === 1'b1) begin
                    act = get_act();
                    checks++;
                    if (act !== exp_q[0]) begin
                        errors++;
                        $display("FAIL model_bundle t=%0t got %h expected %h", $time, act, exp_q[0]);
                    end
                end
                if (flush) begin
                    exp_q.delete();
                    m_ov = 1'b0;
                end else begin
                    ld = (qcnt > 0) && (!m_ov || out_ready);
                    ps = in_valid && (qcnt != DEPTH);
                    if (m_ov && out_ready) void'(exp_q.pop_front());
                    m_ov = ld ? 1'b1 : (out_ready ? 1'b0 : m_ov);
                    if (ps) exp_q.push_back(m_decode(in_pc, in_inst));
                end
            end
        end
    end

    // ---------------- directed stimulus -----------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [XLEN-1:0] pc, input logic [31:0] inst);
        in_valid = 1'b1; in_pc = pc; in_inst = inst;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] fill_tbl [8] = '{32'h000012B7, 32'h00001317, 32'h008003EF, 32'h00010467,
                                  32'h0020A223, 32'h4030D513, 32'h00000073, 32'h0000000F};
    logic [31:0] bnd_inst [12] = '{32'h00011467, 32'h0020A063, 32'h0000B283, 32'h0020B223,
                                   32'h40209033, 32'h02009093, 32'h8000D093, 32'h00500091,
                                   32'h00010467, 32'h0020F063, 32'h0000C283, 32'h4030D513};
    logic        bnd_ill  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t snap;

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_bundle_zero", 64'(get_act() != '0), 64'd0);
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid_after", 64'(out_valid), 64'd0);

        // addi x1,x0,5
        out_ready = 1'b1;
        push1(32'h100, 32'h00500093);
        step();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_rs1", 64'(out_rs1), 64'd0);
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_alu_op", 64'(out_alu_op), 64'd0);
        chk("addi_in2_imm", 64'(out_in2_imm), 64'd1);
        chk("addi_wb", 64'(out_wb), 64'd1);
        chk("addi_illegal", 64'(out_illegal), 64'd0);
        step();

        // sub then add back to back
        in_valid = 1'b1; in_pc = 32'h110; in_inst = 32'h402081B3;
        step();
        in_pc = 32'h114; in_inst = 32'h002081B3;
        step();
        in_valid = 1'b0;
        chk("sub_is_sub", 64'(out_is_sub), 64'd1);
        chk("sub_fields", 64'({out_rd, out_rs1, out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("sub_pc", 64'(out_pc), 64'h110);
        step();
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_is_sub", 64'(out_is_sub), 64'd0);
        chk("add_pc", 64'(out_pc), 64'h114);
        chk("add_fields", 64'({out_rd, out_rs1, out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        step();

        // beq x1,x2,-4
        push1(32'h200, 32'hFE208EE3);
        step();
        chk("beq_is_branch", 64'(out_is_branch), 64'd1);
        chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        chk("beq_in1_pc", 64'(out_in1_pc), 64'd1);
        chk("beq_wb", 64'(out_wb), 64'd0);
        chk("beq_pc", 64'(out_pc), 64'h200);
        step();

        // backpressure: fill until in_ready drops
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (!in_ready) break;
            in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_inst = fill_tbl[i % 8];
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("fill_count", 64'(n), 64'(DEPTH + 1));
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_out_pc", 64'(out_pc), 64'h300);
        snap = get_act();
        repeat (3) step();
        checks++;
        if (get_act() !== snap) begin
            errors++;
            $display("FAIL stall_stable got %h expected %h", get_act(), snap);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_pc", 64'(out_pc), 64'(32'h300 + 32'(4 * k)));
        end
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // illegal followed by lw x5,8(x2)
        out_ready = 1'b0;
        push1(32'h400, 32'hFFFFFFFF);
        push1(32'h404, 32'h00812283);
        chk("ill_illegal", 64'(out_illegal), 64'd1);
        chk("ill_wb", 64'(out_wb), 64'd0);
        out_ready = 1'b1;
        step();
        chk("lw_is_load", 64'(out_is_load), 64'd1);
        chk("lw_imm", 64'(out_imm), 64'd8);
        chk("lw_ls_op", 64'(out_ls_op), 64'd2);
        chk("lw_rd", 64'(out_rd), 64'd5);
        chk("lw_illegal", 64'(out_illegal), 64'd0);
        step();

        // legality boundaries
        for (int i = 0; i < 12; i++) begin
            push1(32'h500 + 32'(4 * i), bnd_inst[i]);
            step();
            chk("boundary_illegal", 64'(out_illegal), 64'(bnd_ill[i]));
        end
        step();

        // flush with 3 queued and a bundle held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(32'h600 + 32'(4 * i), 32'h00100013 + 32'(i << 7));
        chk("preflush_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        push1(32'h700, 32'h00000013);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("flush_no_stale", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        push1(32'h800, 32'h022081B3);
        step();
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_pc", 64'(out_pc), 64'h800);
`ifdef DECODE_RV32M_EN
        chk("mul_is_muldiv", 64'(out_is_muldiv), 64'd1);
        chk("mul_op", 64'(out_muldiv_op), 64'd0);
        chk("mul_wb", 64'(out_wb), 64'd1);
        chk("mul_illegal", 64'(out_illegal), 64'd0);
`else
        chk("mul_illegal", 64'(out_illegal), 64'd1);
        chk("mul_wb", 64'(out_wb), 64'd0);
`endif
        step();

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        push1(32'h900, 32'h00500093);
        push1(32'h904, 32'h00812283);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd1);
        chk("areset_bundle_zero", 64'(get_act() != '0), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        push1(32'hA00, 32'h00812283);
        step();
        chk("post_reset_pc", 64'(out_pc), 64'hA00);
        step();
        chk("post_reset_empty", 64'(out_valid), 64'd0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
